// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_e;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half lane out of a memory word and sign- or zero-extends it.
module mem_load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_word >> {offset, 3'b000};
        data    = mem_word;
        case (size)
            SZ_B: data = is_unsigned ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: data = is_unsigned ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: data = mem_word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory between a fetch port
// and a load-store port; responses are registered one cycle after the grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [AWIDTH-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DWIDTH-1:0]     if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [AWIDTH-1:0]     ls_addr_i,
    input  logic [DWIDTH-1:0]     ls_wdata_i,
    input  logic [1:0]            ls_size_i,
    input  logic                  ls_unsigned_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic                  ls_err_o,
    output logic [DWIDTH-1:0]     ls_rdata_o,
    output logic [AWIDTH-1:0]     mem_addr_o,
    output logic [DWIDTH-1:0]     mem_data_o,
    output logic [DWIDTH/8-1:0]   mem_write_strb_o,
    output logic                  mem_read_en_o,
    output logic                  mem_write_en_o,
    input  logic [DWIDTH-1:0]     mem_data_i,
    input  logic                  mem_data_vld_i
);

    req_e              last_q;
    logic              gnt_if, gnt_ls;
    logic              ls_misalign, ls_rd, ls_wr;
    logic [3:0]        strb;
    logic [DWIDTH-1:0] wdata_rep;
    logic [DWIDTH-1:0] load_data;

    logic              if_rvalid_q, ls_rvalid_q, ls_err_q;
    logic [DWIDTH-1:0] if_rdata_q, ls_rdata_q;

    // The port that lost the last grant wins contention.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (!rst) begin
            if (ls_req_i && (!if_req_i || last_q == REQ_IF))
                gnt_ls = 1'b1;
            else if (if_req_i)
                gnt_if = 1'b1;
        end
    end

    always_comb begin
        ls_misalign = 1'b1;
        strb        = STRB_W;
        wdata_rep   = ls_wdata_i;
        case (ls_size_i)
            SZ_B: begin
                ls_misalign = 1'b0;
                strb        = STRB_B << ls_addr_i[1:0];
                wdata_rep   = {4{ls_wdata_i[7:0]}};
            end
            SZ_H: begin
                ls_misalign = ls_addr_i[0];
                strb        = STRB_H << ls_addr_i[1:0];
                wdata_rep   = {2{ls_wdata_i[15:0]}};
            end
            SZ_W: ls_misalign = |ls_addr_i[1:0];
            default: ls_misalign = 1'b1;
        endcase
    end

    assign ls_rd = gnt_ls && !ls_we_i && !ls_misalign;
    assign ls_wr = gnt_ls &&  ls_we_i && !ls_misalign;

    assign if_gnt_o         = gnt_if;
    assign ls_gnt_o         = gnt_ls;
    assign mem_addr_o       = gnt_if ? {if_addr_i[AWIDTH-1:2], 2'b00} :
                              gnt_ls ? {ls_addr_i[AWIDTH-1:2], 2'b00} : '0;
    assign mem_read_en_o    = gnt_if || ls_rd;
    assign mem_write_en_o   = ls_wr;
    assign mem_write_strb_o = ls_wr ? strb : '0;
    assign mem_data_o       = ls_wr ? wdata_rep : '0;

    mem_load_align u_load_align (
        .mem_word    (mem_data_i),
        .offset      (ls_addr_i[1:0]),
        .size        (ls_size_i),
        .is_unsigned (ls_unsigned_i),
        .data        (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= REQ_IF;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            if (gnt_ls)
                last_q <= REQ_LS;
            else if (gnt_if)
                last_q <= REQ_IF;
            if_rvalid_q <= gnt_if;
            if_rdata_q  <= gnt_if ? mem_data_i : '0;
            ls_rvalid_q <= gnt_ls;
            ls_err_q    <= gnt_ls && ls_misalign;
            ls_rdata_q  <= ls_rd ? load_data : '0;
        end
    end

    // Responses are also masked while reset is held, not only after the next edge.
    assign if_rvalid_o = if_rvalid_q && !rst;
    assign if_rdata_o  = rst ? '0 : if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q && !rst;
    assign ls_err_o    = ls_err_q && !rst;
    assign ls_rdata_o  = rst ? '0 : ls_rdata_q;

`ifndef SYNTHESIS
    read_data_valid: assert property (@(posedge clk) disable iff (rst)
        mem_read_en_o |-> mem_data_vld_i);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset/contention sequence, then random traffic vs a reference model.
module tb_mem_arbiter;

    localparam logic [31:0] A = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i = 1'b0, ls_we_i = 1'b0, ls_unsigned_i = 1'b0;
    logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
    logic [1:0]  ls_size_i = '0;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_write_strb_o;
    logic        mem_read_en_o, mem_write_en_o, mem_data_vld_i;

    logic [31:0] tbmem [0:255];
    logic [31:0] mmem  [0:255];

    int n_tests = 0;
    int n_fail  = 0;
    int m_last  = 0;   // 0: fetch port granted most recently, 1: load-store port

    logic        p_ivld = 1'b0, p_lvld = 1'b0, p_lerr = 1'b0;
    logic [31:0] p_ird = '0, p_lrd = '0;

    typedef struct {
        logic        rst, ifr;
        logic [31:0] ifa;
        logic        lsr, we;
        logic [31:0] lsa, wd;
        logic [1:0]  sz;
        logic        un;
        logic        egi, egl;
        logic [31:0] eaddr;
        logic        erd, ewr;
        logic [3:0]  estrb;
        logic [31:0] edata;
        logic        eivld;
        logic [31:0] eird;
        logic        elvld, eerr;
        logic [31:0] elrd;
    } vec_t;

    vec_t tbl[$];

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_size_i(ls_size_i), .ls_unsigned_i(ls_unsigned_i),
        .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_err_o(ls_err_o),
        .ls_rdata_o(ls_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_write_strb_o(mem_write_strb_o), .mem_read_en_o(mem_read_en_o),
        .mem_write_en_o(mem_write_en_o), .mem_data_i(mem_data_i),
        .mem_data_vld_i(mem_data_vld_i)
    );

    always #5 clk = ~clk;

    assign mem_data_i     = tbmem[mem_addr_o[9:2]];
    assign mem_data_vld_i = mem_read_en_o;

    function automatic vec_t vin(input int r, input int ifr, input logic [31:0] ifa,
                                 input int lsr, input int we, input logic [31:0] lsa,
                                 input logic [31:0] wd, input int sz, input int un);
        vec_t v;
        v = '{default: '0};
        v.rst = (r != 0); v.ifr = (ifr != 0); v.ifa = ifa;
        v.lsr = (lsr != 0); v.we = (we != 0); v.lsa = lsa; v.wd = wd;
        v.sz = 2'(sz); v.un = (un != 0);
        return v;
    endfunction

    function automatic vec_t vexp(input vec_t vi, input int gi, input int gl, input logic [31:0] addr,
                                  input int rd, input int wr, input int strb, input logic [31:0] data,
                                  input int ivld, input logic [31:0] ird,
                                  input int lvld, input int lerr, input logic [31:0] lrd);
        vec_t v;
        v = vi;
        v.egi = (gi != 0); v.egl = (gl != 0); v.eaddr = addr;
        v.erd = (rd != 0); v.ewr = (wr != 0); v.estrb = 4'(strb); v.edata = data;
        v.eivld = (ivld != 0); v.eird = ird;
        v.elvld = (lvld != 0); v.eerr = (lerr != 0); v.elrd = lrd;
        return v;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic apply(input vec_t v);
        logic       w_en;
        logic [3:0] w_strb;
        logic [7:0] w_idx;
        logic [31:0] w_data;
        rst = v.rst; if_req_i = v.ifr; if_addr_i = v.ifa;
        ls_req_i = v.lsr; ls_we_i = v.we; ls_addr_i = v.lsa; ls_wdata_i = v.wd;
        ls_size_i = v.sz; ls_unsigned_i = v.un;
        #2;
        if (v.rst) begin
            p_ivld = 1'b0; p_ird = '0; p_lvld = 1'b0; p_lerr = 1'b0; p_lrd = '0;
        end
        chk("if_rvalid", 32'(if_rvalid_o), 32'(p_ivld));
        if (p_ivld || v.rst) chk("if_rdata", if_rdata_o, p_ird);
        chk("ls_rvalid", 32'(ls_rvalid_o), 32'(p_lvld));
        chk("ls_err", 32'(ls_err_o), 32'(p_lerr));
        if (p_lvld || v.rst) chk("ls_rdata", ls_rdata_o, p_lrd);
        chk("if_gnt", 32'(if_gnt_o), 32'(v.egi));
        chk("ls_gnt", 32'(ls_gnt_o), 32'(v.egl));
        chk("mem_addr", mem_addr_o, v.eaddr);
        chk("mem_read_en", 32'(mem_read_en_o), 32'(v.erd));
        chk("mem_write_en", 32'(mem_write_en_o), 32'(v.ewr));
        if (v.ewr || !(v.egi || v.egl)) begin
            chk("mem_strb", 32'(mem_write_strb_o), 32'(v.estrb));
            chk("mem_data", mem_data_o, v.edata);
        end
        p_ivld = v.eivld; p_ird = v.eird; p_lvld = v.elvld; p_lerr = v.eerr; p_lrd = v.elrd;
        if (v.ewr)
            for (int i = 0; i < 4; i++)
                if (v.estrb[i]) mmem[v.eaddr[9:2]][8*i +: 8] = v.edata[8*i +: 8];
        w_en = mem_write_en_o; w_strb = mem_write_strb_o; w_idx = mem_addr_o[9:2]; w_data = mem_data_o;
        @(posedge clk);
        if (w_en)
            for (int i = 0; i < 4; i++)
                if (w_strb[i]) tbmem[w_idx][8*i +: 8] = w_data[8*i +: 8];
        #1;
    endtask

    // Reference model: picks the winner from "who was served last", and computes
    // memory effects and load results with plain byte arithmetic on its own memory copy.
    function automatic vec_t gen(input bit force_rst);
        vec_t v;
        logic [31:0] w, sh, val, wdat;
        int off, winner;
        bit err;
        v = vin(force_rst || ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                A | 32'($urandom_range(0, 1023)), $urandom_range(0, 1), $urandom_range(0, 1),
                A | 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
        if (v.rst) begin
            m_last = 0;
            return v;
        end
        winner = -1;
        if (v.ifr && v.lsr) winner = (m_last == 0) ? 1 : 0;
        else if (v.ifr)     winner = 0;
        else if (v.lsr)     winner = 1;
        if (winner == 0) begin
            m_last = 0;
            v.egi = 1'b1; v.eaddr = v.ifa & ~32'd3; v.erd = 1'b1;
            v.eivld = 1'b1; v.eird = mmem[v.ifa[9:2]];
        end else if (winner == 1) begin
            m_last = 1;
            off = int'(v.lsa % 4);
            err = (v.sz == 2'd3) || (v.sz == 2'd1 && off % 2 != 0) || (v.sz == 2'd2 && off != 0);
            v.egl = 1'b1; v.eaddr = v.lsa & ~32'd3; v.elvld = 1'b1; v.eerr = err;
            if (!err && v.we) begin
                v.ewr = 1'b1;
                case (v.sz)
                    2'd0: begin v.estrb = 4'(1 << off); wdat = 32'(v.wd[7:0]) * 32'h0101_0101; end
                    2'd1: begin v.estrb = 4'(3 << off); wdat = 32'(v.wd[15:0]) * 32'h0001_0001; end
                    default: begin v.estrb = 4'hF; wdat = v.wd; end
                endcase
                v.edata = wdat;
            end else if (!err) begin
                v.erd = 1'b1;
                w = mmem[v.lsa[9:2]];
                sh = w >> (8 * off);
                case (v.sz)
                    2'd0: begin val = sh & 32'hFF;   if (!v.un && val[7])  val = val | 32'hFFFF_FF00; end
                    2'd1: begin val = sh & 32'hFFFF; if (!v.un && val[15]) val = val | 32'hFFFF_0000; end
                    default: val = w;
                endcase
                v.elrd = val;
            end
        end
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbmem[i] = '0;
            mmem[i]  = '0;
        end
        tbmem[1] = 32'hCAFE_F00D;
        mmem[1]  = 32'hCAFE_F00D;

        //                  rst ifr ifa     lsr we lsa         wd            sz un    gi gl addr        rd wr strb    data          ivld ird           lvld err lrd
        tbl.push_back(vexp(vin(1, 1, A+4,   1, 0, A+32'h200, 0,            2, 1), 0, 0, 0,          0, 0, 0,      0,            0, 0,            0, 0, 0));
        tbl.push_back(vexp(vin(0, 1, A+4,   0, 0, 0,         0,            0, 0), 1, 0, A+4,        1, 0, 0,      0,            1, 32'hCAFEF00D, 0, 0, 0));
        tbl.push_back(vexp(vin(0, 1, A+4,   1, 0, A+32'h200, 0,            2, 1), 0, 1, A+32'h200,  1, 0, 0,      0,            0, 0,            1, 0, 0));
        tbl.push_back(vexp(vin(0, 1, A+4,   1, 0, A+32'h200, 0,            2, 1), 1, 0, A+4,        1, 0, 0,      0,            1, 32'hCAFEF00D, 0, 0, 0));
        tbl.push_back(vexp(vin(0, 1, A+4,   1, 0, A+32'h200, 0,            2, 1), 0, 1, A+32'h200,  1, 0, 0,      0,            0, 0,            1, 0, 0));
        tbl.push_back(vexp(vin(0, 1, A+4,   1, 0, A+32'h200, 0,            2, 1), 1, 0, A+4,        1, 0, 0,      0,            1, 32'hCAFEF00D, 0, 0, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 1, A+32'h102, 32'hAB,       0, 0), 0, 1, A+32'h100,  0, 1, 4'b0100, 32'hABABABAB, 0, 0,           1, 0, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 0, A+32'h102, 0,            0, 0), 0, 1, A+32'h100,  1, 0, 0,      0,            0, 0,            1, 0, 32'hFFFFFFAB));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 0, A+32'h102, 0,            0, 1), 0, 1, A+32'h100,  1, 0, 0,      0,            0, 0,            1, 0, 32'h000000AB));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 1, A+32'h101, 32'h12345678, 2, 0), 0, 1, A+32'h100,  0, 0, 0,      0,            0, 0,            1, 1, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 0, A+32'h100, 0,            2, 0), 0, 1, A+32'h100,  1, 0, 0,      0,            0, 0,            1, 0, 32'h00AB0000));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 1, A+32'h200, 32'h80001234, 2, 0), 0, 1, A+32'h200,  0, 1, 4'hF,   32'h80001234, 0, 0,           1, 0, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 0, A+32'h202, 0,            1, 0), 0, 1, A+32'h200,  1, 0, 0,      0,            0, 0,            1, 0, 32'hFFFF8000));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 0, A+32'h200, 0,            3, 0), 0, 1, A+32'h200,  0, 0, 0,      0,            0, 0,            1, 1, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 1, A+32'h201, 32'h5555,     1, 0), 0, 1, A+32'h200,  0, 0, 0,      0,            0, 0,            1, 1, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 1, A+2,       32'h0000BEEF, 1, 0), 0, 1, A,          0, 1, 4'b1100, 32'hBEEFBEEF, 0, 0,           1, 0, 0));
        tbl.push_back(vexp(vin(0, 0, 0,     1, 0, A,         0,            2, 1), 0, 1, A,          1, 0, 0,      0,            0, 0,            1, 0, 32'hBEEF0000));
        tbl.push_back(vexp(vin(0, 0, 0,     0, 0, 0,         0,            0, 0), 0, 0, 0,          0, 0, 0,      0,            0, 0,            0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);
        chk("word_unchanged_after_misaligned", tbmem[8'h40], 32'h00AB0000);

        // Reset lands on a store request after a load-store grant; the store must vanish
        // and the load-store port must still win the first contention afterwards.
        apply(vexp(vin(0, 0, 0, 1, 0, A+32'h200, 0, 2, 0), 0, 1, A+32'h200, 1, 0, 0, 0, 0, 0, 1, 0, 32'h80001234));
        apply(vexp(vin(1, 1, A+4, 1, 1, A+32'h300, 32'h5555AAAA, 2, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("no_write_in_reset", tbmem[8'hC0], 32'h0);
        apply(vexp(vin(0, 1, A+4, 1, 0, A+32'h300, 0, 2, 0), 0, 1, A+32'h300, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        apply(vexp(vin(0, 1, A+4, 1, 0, A+32'h300, 0, 2, 0), 1, 0, A+4, 1, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0));
        apply(vexp(vin(0, 1, A+4, 1, 0, A+32'h300, 0, 2, 0), 0, 1, A+32'h300, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        apply(vexp(vin(0, 1, A+4, 1, 0, A+32'h300, 0, 2, 0), 1, 0, A+4, 1, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0));

        for (int k = 0; k < 800; k++) apply(gen(k == 0));
        apply(vexp(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 256; i++)
            if (tbmem[i] !== mmem[i]) chk("final_memory_image", tbmem[i], mmem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
